// File: rtl/carrega_matriz.sv
// carrega_matriz: serial loader for an N_ELEM-element signed matrix.
// Elements arrive one per valid/ready handshake, are collected in an internal
// buffer and published on matriz_A only when the last element is accepted.
// The matrix is then held until the downstream stage acknowledges it.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-high reset
//   elem_in      - signed element from upstream (W bits)
//   elem_valid   - elem_in valid this cycle
//   elem_ready   - element accepted this cycle (combinational)
//   limpa        - abort a partially loaded matrix (ignored in HOLD)
//   matriz_A     - last complete matrix, element i at [i*W +: W]
//   matriz_valid - matriz_A holds a complete, unconsumed matrix
//   matriz_ack   - downstream has consumed matriz_A (ignored in LOAD)
//   satura_flag  - sticky: a -2^(W-1) element was clamped
//
// Optional feature: define CARREGA_MATRIZ_SATURA_EN to clamp -2^(W-1) to
// -2^(W-1)+1 before storing, so a later negation cannot overflow. Without it
// elements are stored unmodified and satura_flag stays 0.
module carrega_matriz #(
  parameter int unsigned N_ELEM = 25,
  parameter int unsigned W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [W-1:0]   elem_in,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  input  logic                  limpa,
  output logic [N_ELEM*W-1:0]   matriz_A,
  output logic                  matriz_valid,
  input  logic                  matriz_ack,
  output logic                  satura_flag
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned MAT_W = N_ELEM * W;

`ifdef CARREGA_MATRIZ_SATURA_EN
  localparam logic [W-1:0] ELEM_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ELEM_MIN_P1 = {1'b1, {(W-2){1'b0}}, 1'b1};
`endif

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MAT_W-1:0]   buf_q, buf_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic               valid_q, valid_d;
  logic               satura_q, satura_d;
  logic [W-1:0]       elem_st;
  logic               sat_hit;

  // Ready is combinational so an upstream source sees it in the same cycle.
  assign elem_ready   = (state_q == LOAD) && !reset;
  assign matriz_A     = mat_q;
  assign matriz_valid = valid_q;
  assign satura_flag  = satura_q;

  // Element value as it will be stored (optionally clamped).
  always_comb begin
    elem_st = elem_in;
    sat_hit = 1'b0;
`ifdef CARREGA_MATRIZ_SATURA_EN
    if (elem_in == ELEM_MIN) begin
      elem_st = ELEM_MIN_P1;
      sat_hit = 1'b1;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    mat_d    = mat_q;
    valid_d  = valid_q;
    satura_d = satura_q;

    unique case (state_q)
      LOAD: begin
        // limpa wins over an element offered in the same cycle.
        if (limpa) begin
          idx_d = '0;
        end else if (elem_valid) begin
          for (int i = 0; i < int'(N_ELEM); i++) begin
            if (idx_q == IDX_W'(i)) begin
              buf_d[i*W +: W] = elem_st;
            end
          end
          satura_d = satura_q | sat_hit;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            // Publish the buffer including the element accepted at this edge.
            mat_d   = buf_d;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (matriz_ack) begin
          valid_d = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      buf_q    <= '0;
      mat_q    <= '0;
      valid_q  <= 1'b0;
      satura_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      mat_q    <= mat_d;
      valid_q  <= valid_d;
      satura_q <= satura_d;
    end
  end

endmodule
